// File: rtl/alu_response_checker.sv
// alu_response_checker
//
// On-chip responder for the ALU stimulus/response interface. Each accepted
// transaction (operands, control code, ALU-reported result and flags) is
// re-evaluated against a golden ALU model, and pass/fail/illegal counts are
// accumulated. The first failing transaction is captured for post-mortem.
//
// Pipeline: stage 1 registers the accepted transaction, stage 2 holds it
// together with the golden value, and the compare result updates the counters
// and the capture on the following edge. A transaction accepted at edge N is
// reflected in the counters and the mismatch pulse at edge N+2.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start, stop              control pulses (start clears and runs; stop drains)
//   in_valid / in_ready      transaction handshake (in_ready only in RUN)
//   in_a, in_b, in_ctr       operands and ALU control code
//   in_result, in_carry, in_overflow, in_zero, in_negative
//                            ALU-reported result and flags
//   mismatch                 one-cycle pulse per failing transaction
//   pass_cnt, fail_cnt, illegal_cnt
//                            saturating counters
//   err_valid, err_ctr, err_a, err_b, err_result, err_expected
//                            sticky first-failure capture
//   busy, done               RUN/DRAIN and DONE status
//
// Build option: define ALU_CHK_FLAGS_EN to require the four flags to match
// as well as the result. Without it only the result is compared and the flag
// inputs are ignored.
//
// state | meaning
// IDLE  | after reset, nothing accepted
// RUN   | accepting transactions
// DRAIN | stop seen, finishing in-flight transactions
// DONE  | pipeline empty, counters final

module alu_response_checker #(
    parameter int WIDTH     = 32,
    parameter int CTR_WIDTH = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [CTR_WIDTH-1:0] in_ctr,
    input  logic [WIDTH-1:0]     in_result,
    input  logic                 in_carry,
    input  logic                 in_overflow,
    input  logic                 in_zero,
    input  logic                 in_negative,
    output logic                 mismatch,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt,
    output logic [CNT_WIDTH-1:0] illegal_cnt,
    output logic                 err_valid,
    output logic [CTR_WIDTH-1:0] err_ctr,
    output logic [WIDTH-1:0]     err_a,
    output logic [WIDTH-1:0]     err_b,
    output logic [WIDTH-1:0]     err_result,
    output logic [WIDTH-1:0]     err_expected,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CTR_WIDTH-1:0] OP_ADD = CTR_WIDTH'(0);
    localparam logic [CTR_WIDTH-1:0] OP_SUB = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] OP_AND = CTR_WIDTH'(2);
    localparam logic [CTR_WIDTH-1:0] OP_OR  = CTR_WIDTH'(3);
    localparam logic [CTR_WIDTH-1:0] OP_SLT = CTR_WIDTH'(5);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q;
    logic   in_ready_q;
    logic   busy_q;
    logic   done_q;

    logic                 accept;
    logic                 s1_valid_q;
    logic [WIDTH-1:0]     s1_a_q;
    logic [WIDTH-1:0]     s1_b_q;
    logic [WIDTH-1:0]     s1_res_q;
    logic [CTR_WIDTH-1:0] s1_ctr_q;

    logic                 s2_valid_q;
    logic [WIDTH-1:0]     s2_a_q;
    logic [WIDTH-1:0]     s2_b_q;
    logic [WIDTH-1:0]     s2_res_q;
    logic [WIDTH-1:0]     s2_exp_q;
    logic [CTR_WIDTH-1:0] s2_ctr_q;
    logic                 s2_illegal_q;
    logic                 s2_match;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_sum;
    logic                 slt_d;
    logic [WIDTH-1:0]     exp_res_d;
    logic                 exp_c_d;
    logic                 exp_v_d;
    logic                 exp_z_d;
    logic                 exp_n_d;
    logic                 illegal_d;

    logic                 mismatch_q;
    logic [CNT_WIDTH-1:0] pass_cnt_q;
    logic [CNT_WIDTH-1:0] fail_cnt_q;
    logic [CNT_WIDTH-1:0] illegal_cnt_q;
    logic                 err_valid_q;
    logic [CTR_WIDTH-1:0] err_ctr_q;
    logic [WIDTH-1:0]     err_a_q;
    logic [WIDTH-1:0]     err_b_q;
    logic [WIDTH-1:0]     err_result_q;
    logic [WIDTH-1:0]     err_expected_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Control FSM; in_ready/busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (start) begin
            state_q    <= ST_RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop) begin
                        state_q    <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid_q && !s2_valid_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign accept = in_valid & in_ready_q;

    // Golden model evaluated on the stage-1 contents.
    assign add_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign sub_sum = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + (WIDTH+1)'(1);
    assign slt_d   = $signed(s1_a_q) < $signed(s1_b_q);

    always_comb begin
        exp_res_d = '0;
        exp_c_d   = 1'b0;
        exp_v_d   = 1'b0;
        illegal_d = 1'b0;
        case (s1_ctr_q)
            OP_ADD: begin
                exp_res_d = add_sum[WIDTH-1:0];
                exp_c_d   = add_sum[WIDTH];
                // same-sign operands producing an opposite-sign sum
                exp_v_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exp_res_d = sub_sum[WIDTH-1:0];
                exp_c_d   = sub_sum[WIDTH];
                exp_v_d   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                            (sub_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND:  exp_res_d = s1_a_q & s1_b_q;
            OP_OR:   exp_res_d = s1_a_q | s1_b_q;
            OP_SLT:  exp_res_d = {{(WIDTH-1){1'b0}}, slt_d};
            default: illegal_d = 1'b1;
        endcase
    end

    assign exp_z_d = (exp_res_d == '0);
    assign exp_n_d = exp_res_d[WIDTH-1];

`ifdef ALU_CHK_FLAGS_EN
    logic [3:0] s1_flags_q;
    logic [3:0] s2_flags_q;
    logic [3:0] s2_exp_flags_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_flags_q <= {in_carry, in_overflow, in_zero, in_negative};
        end
        if (s1_valid_q) begin
            s2_flags_q     <= s1_flags_q;
            s2_exp_flags_q <= {exp_c_d, exp_v_d, exp_z_d, exp_n_d};
        end
    end

    assign s2_match = (s2_res_q == s2_exp_q) && (s2_flags_q == s2_exp_flags_q);
`else
    logic unused_flags;
    assign unused_flags = ^{in_carry, in_overflow, in_zero, in_negative,
                            exp_c_d, exp_v_d, exp_z_d, exp_n_d};

    assign s2_match = (s2_res_q == s2_exp_q);
`endif

    // Pipeline payload; qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a_q   <= in_a;
            s1_b_q   <= in_b;
            s1_res_q <= in_result;
            s1_ctr_q <= in_ctr;
        end
        if (s1_valid_q) begin
            s2_a_q       <= s1_a_q;
            s2_b_q       <= s1_b_q;
            s2_res_q     <= s1_res_q;
            s2_ctr_q     <= s1_ctr_q;
            s2_exp_q     <= exp_res_d;
            s2_illegal_q <= illegal_d;
        end
    end

    // Valid bits, counters and first-failure capture. start flushes the
    // pipeline exactly like reset does, including a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            s1_valid_q     <= 1'b0;
            s2_valid_q     <= 1'b0;
            mismatch_q     <= 1'b0;
            pass_cnt_q     <= '0;
            fail_cnt_q     <= '0;
            illegal_cnt_q  <= '0;
            err_valid_q    <= 1'b0;
            err_ctr_q      <= '0;
            err_a_q        <= '0;
            err_b_q        <= '0;
            err_result_q   <= '0;
            err_expected_q <= '0;
        end else begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            mismatch_q <= 1'b0;
            if (s2_valid_q) begin
                if (s2_illegal_q) begin
                    illegal_cnt_q <= sat_inc(illegal_cnt_q);
                end else if (s2_match) begin
                    pass_cnt_q <= sat_inc(pass_cnt_q);
                end else begin
                    fail_cnt_q <= sat_inc(fail_cnt_q);
                    mismatch_q <= 1'b1;
                    if (!err_valid_q) begin
                        err_valid_q    <= 1'b1;
                        err_ctr_q      <= s2_ctr_q;
                        err_a_q        <= s2_a_q;
                        err_b_q        <= s2_b_q;
                        err_result_q   <= s2_res_q;
                        err_expected_q <= s2_exp_q;
                    end
                end
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch     = mismatch_q;
    assign pass_cnt     = pass_cnt_q;
    assign fail_cnt     = fail_cnt_q;
    assign illegal_cnt  = illegal_cnt_q;
    assign err_valid    = err_valid_q;
    assign err_ctr      = err_ctr_q;
    assign err_a        = err_a_q;
    assign err_b        = err_b_q;
    assign err_result   = err_result_q;
    assign err_expected = err_expected_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Bench for alu_response_checker: independent golden ALU model, scoreboard
// queue of expected outcomes keyed by the cycle they must appear, and a
// negedge monitor that retires entries and compares counters and mismatch.

module tb_alu_response_checker;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_ctr = '0;
    logic [31:0] in_result = '0;
    logic        in_carry = 1'b0;
    logic        in_overflow = 1'b0;
    logic        in_zero = 1'b0;
    logic        in_negative = 1'b0;
    logic        mismatch;
    logic [15:0] pass_cnt, fail_cnt, illegal_cnt;
    logic        err_valid;
    logic [2:0]  err_ctr;
    logic [31:0] err_a, err_b, err_result, err_expected;
    logic        busy, done;

    alu_response_checker #(.WIDTH(32), .CTR_WIDTH(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctr(in_ctr), .in_result(in_result),
        .in_carry(in_carry), .in_overflow(in_overflow),
        .in_zero(in_zero), .in_negative(in_negative),
        .mismatch(mismatch), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .illegal_cnt(illegal_cnt), .err_valid(err_valid), .err_ctr(err_ctr),
        .err_a(err_a), .err_b(err_b), .err_result(err_result),
        .err_expected(err_expected), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        longint      due;
        int          kind;   // 0 pass, 1 fail, 2 illegal
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] expv;
        logic [2:0]  ctr;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    int          m_pass = 0, m_fail = 0, m_ill = 0;
    bit          m_errv = 1'b0;
    logic [31:0] m_ea = '0, m_eb = '0, m_eres = '0, m_eexp = '0;
    logic [2:0]  m_ectr = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic void golden(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] ctr, output logic [31:0] r,
                                   output logic [3:0] f, output bit ill);
        longint      sa, sbv, s;
        logic [63:0] u;
        logic        c, v;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (ctr)
            3'd0: begin
                u = {32'd0, a} + {32'd0, b};
                r = u[31:0];
                c = u[32];
                s = sa + sbv;
                v = (s > SMAX) || (s < SMIN);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sbv;
                v = (s > SMAX) || (s < SMIN);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = (sa < sbv) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
        f = {c, v, (r == 32'd0), r[31]};
    endfunction

    task automatic clear_model();
        sb_q.delete();
        m_pass = 0; m_fail = 0; m_ill = 0; m_errv = 1'b0;
        m_ea = '0; m_eb = '0; m_eres = '0; m_eexp = '0; m_ectr = '0;
    endtask

    // flags ordered {carry, overflow, zero, negative}
    task automatic drive_tx(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctr,
                            input logic [31:0] res, input logic [3:0] flags);
        logic [31:0] gr;
        logic [3:0]  gf;
        bit          ill, ok;
        sb_t         e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_ctr = ctr; in_result = res;
        {in_carry, in_overflow, in_zero, in_negative} = flags;
        if (in_ready === 1'b1) begin
            golden(a, b, ctr, gr, gf, ill);
            ok = (res == gr);
`ifdef ALU_CHK_FLAGS_EN
            ok = ok && (flags == gf);
`endif
            e.due  = cyc + 3;
            e.kind = ill ? 2 : (ok ? 0 : 1);
            e.a = a; e.b = b; e.res = res; e.expv = gr; e.ctr = ctr;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (sb_q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) check_val("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_start();
        @(negedge clk);
        in_valid = 1'b0;
        mon_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_model();
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        sb_t e;
        logic exp_mm;
        if (mon_en) begin
            exp_mm = 1'b0;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                if (e.due != cyc) check_val("sb_late", 64'(e.due), 64'(cyc));
                if (e.kind == 2) m_ill++;
                else if (e.kind == 0) m_pass++;
                else begin
                    m_fail++;
                    exp_mm = 1'b1;
                    if (!m_errv) begin
                        m_errv = 1'b1;
                        m_ea = e.a; m_eb = e.b; m_eres = e.res; m_eexp = e.expv; m_ectr = e.ctr;
                    end
                end
            end
            check_val("pass_cnt", 64'(pass_cnt), 64'(m_pass));
            check_val("fail_cnt", 64'(fail_cnt), 64'(m_fail));
            check_val("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
            check_val("mismatch", 64'(mismatch), 64'(exp_mm));
        end
    end

    task automatic check_capture(input string tag);
        check_val({tag, "_err_valid"}, 64'(err_valid), 64'(m_errv));
        check_val({tag, "_err_a"}, 64'(err_a), 64'(m_ea));
        check_val({tag, "_err_b"}, 64'(err_b), 64'(m_eb));
        check_val({tag, "_err_result"}, 64'(err_result), 64'(m_eres));
        check_val({tag, "_err_expected"}, 64'(err_expected), 64'(m_eexp));
        check_val({tag, "_err_ctr"}, 64'(err_ctr), 64'(m_ectr));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_mismatch"}, 64'(mismatch), 64'd0);
        check_val({tag, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
        check_val({tag, "_fail_cnt"}, 64'(fail_cnt), 64'd0);
        check_val({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'd0);
        check_val({tag, "_err_valid"}, 64'(err_valid), 64'd0);
        check_val({tag, "_err_expected"}, 64'(err_expected), 64'd0);
        check_val({tag, "_err_a"}, 64'(err_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, gr;
        logic [3:0]  gf;
        bit          ill;
        logic [2:0]  rc;
        int          waited;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        do_start();
        check_val("start_in_ready", 64'(in_ready), 64'd1);
        check_val("start_busy", 64'(busy), 64'd1);

        // directed cases
        drive_tx(32'd15, 32'd10, 3'b000, 32'd25, 4'b0000);
        drive_tx(32'd10, 32'd15, 3'b001, 32'hFFFF_FFFB, 4'b0001);
        drive_tx(32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 4'b0001);
        drive_tx(32'd5, 32'd10, 3'b101, 32'd1, 4'b0000);
        drive_tx(32'd1, 32'd2, 3'b111, 32'd0, 4'b0000);
        drive_tx(32'h0000_F0F0, 32'h0000_0FF0, 3'b010, 32'd0, 4'b0010);
        drive_tx(32'd1, 32'd2, 3'b011, 32'd7, 4'b0000);
        drive_tx(32'hFFFF_FFFF, 32'd1, 3'b001, 32'hFFFF_FFFE, 4'b1001);
        drive_tx(32'h8000_0000, 32'd1, 3'b101, 32'd1, 4'b0000);
        drive_tx(32'd9, 32'd9, 3'b100, 32'd0, 4'b0000);
        drive_tx(32'd9, 32'd9, 3'b110, 32'd0, 4'b0000);
        wait_drain();
        check_capture("directed");

        // random back-to-back traffic, roughly a quarter corrupted
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rc = 3'($urandom_range(0, 7));
            if (i % 4 == 0) rb = ra;
            golden(ra, rb, rc, gr, gf, ill);
            if ($urandom_range(0, 3) == 0) gr = gr ^ 32'h0000_0100;
            drive_tx(ra, rb, rc, gr, gf);
        end
        wait_drain();
        check_capture("random");

        // stop with two transactions in flight
        drive_tx(32'd1, 32'd2, 3'b000, 32'd3, 4'b0000);
        drive_tx(32'd7, 32'd3, 3'b001, 32'd4, 4'b1000);
        drive_tx(32'd6, 32'd3, 3'b010, 32'd2, 4'b0000);
        drive_tx(32'd6, 32'd3, 3'b011, 32'd9, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        in_valid = 1'b1;
        in_a = 32'd2; in_b = 32'd2; in_ctr = 3'b000; in_result = 32'd4;
        {in_carry, in_overflow, in_zero, in_negative} = 4'b0000;
        check_val("stop_in_ready", 64'(in_ready), 64'd0);
        check_val("stop_busy", 64'(busy), 64'd1);
        waited = 0;
        while (done !== 1'b1 && waited < 3) begin
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
        check_val("stop_done_within_3", 64'(done), 64'd1);
        check_val("stop_busy_after", 64'(busy), 64'd0);
        check_val("stop_in_flight_drained", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check_val("done_hold", 64'(done), 64'd1);

        // restart from DONE, then reset one cycle after an accept
        do_start();
        check_val("restart_done", 64'(done), 64'd0);
        check_val("restart_pass_cnt", 64'(pass_cnt), 64'd0);
        check_val("restart_err_valid", 64'(err_valid), 64'd0);
        drive_tx(32'd3, 32'd4, 3'b000, 32'd8, 4'b0000);
        wait_drain();
        check_val("pre_rst_err_valid", 64'(err_valid), 64'd1);
        drive_tx(32'd3, 32'd4, 3'b000, 32'd7, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        check_idle_outputs("mid_rst");
        @(negedge clk);
        check_idle_outputs("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
